// File: rtl/rob_commit.sv
// Reorder buffer commit stage.
// Issue allocates entries in program order at the tail. Writeback results complete entries
// out of order. The head retires in order, at most one entry per cycle, through a registered
// register-file write port. Flush discards every in-flight entry.
//
// Ports:
//   clk_in, rst_in          clock (rising edge), synchronous active-high reset
//   flush                   discard all entries (highest priority after reset)
//   alloc_valid/rd/ready/tag  allocation handshake; alloc_tag is the current tail
//   wb_valid/tag/value      writeback (CDB) completion
//   query_tag/ready/value   operand lookup into the buffer
//   rf_we/index/value       registered register-file write port
//   empty                   no entries in flight
module rob_commit #(
  parameter int unsigned ROB_SIZE = 16,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned DATA_W   = 64
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [4:0]        alloc_rd,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_value,
  input  logic [TAG_W-1:0]  query_tag,
  output logic              query_ready,
  output logic [DATA_W-1:0] query_value,
  output logic              rf_we,
  output logic [4:0]        rf_index,
  output logic [DATA_W-1:0] rf_value,
  output logic              empty
);

  localparam logic [TAG_W:0] CountFull = (TAG_W + 1)'(ROB_SIZE);

  logic [ROB_SIZE-1:0] busy_q, busy_d;
  logic [ROB_SIZE-1:0] done_q, done_d;
  logic [4:0]          rd_q    [ROB_SIZE];
  logic [DATA_W-1:0]   value_q [ROB_SIZE];

  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_index_q, rf_index_d;
  logic [DATA_W-1:0] rf_value_q, rf_value_d;

  logic do_alloc;
  logic do_commit;
  logic wb_hit;

  // Full blocks allocation even if the head commits this cycle.
  assign alloc_ready = (count_q != CountFull) && !flush;
  assign alloc_tag   = tail_q;
  assign empty       = (count_q == '0);

  // No bypass: a writeback becomes visible here the cycle after it lands.
  assign query_ready = busy_q[query_tag] && done_q[query_tag];
  assign query_value = busy_q[query_tag] ? value_q[query_tag] : '0;

  assign rf_we    = rf_we_q;
  assign rf_index = rf_index_q;
  assign rf_value = rf_value_q;

  assign do_alloc  = alloc_valid && alloc_ready;
  // Commit looks only at registered state, so a same-cycle writeback retires next cycle.
  assign do_commit = busy_q[head_q] && done_q[head_q];
  assign wb_hit    = wb_valid && busy_q[wb_tag];

  always_comb begin
    busy_d     = busy_q;
    done_d     = done_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    rf_we_d    = 1'b0;
    rf_index_d = rf_index_q;
    rf_value_d = rf_value_q;

    if (flush) begin
      busy_d  = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wb_hit) begin
        done_d[wb_tag] = 1'b1;
      end
      // Commit after writeback so a retiring head is cleared even if written this cycle.
      if (do_commit) begin
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
        head_d         = head_q + TAG_W'(1);
        rf_we_d        = (rd_q[head_q] != 5'd0);
        rf_index_d     = rd_q[head_q];
        rf_value_d     = value_q[head_q];
      end
      // Tail slot is never busy when allocation is allowed, so it cannot collide with the above.
      if (do_alloc) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        tail_d         = tail_q + TAG_W'(1);
      end
      unique case ({do_alloc, do_commit})
        2'b10:   count_d = count_q + (TAG_W + 1)'(1);
        2'b01:   count_d = count_q - (TAG_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q     <= '0;
      done_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_index_q <= '0;
      rf_value_q <= '0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_index_q <= rf_index_d;
      rf_value_q <= rf_value_d;
    end
  end

  // Payload storage needs no reset; busy/done qualify every read.
  always_ff @(posedge clk_in) begin
    if (!rst_in && !flush) begin
      if (do_alloc) begin
        rd_q[tail_q] <= alloc_rd;
      end
      if (wb_hit) begin
        value_q[wb_tag] <= wb_value;
      end
    end
  end

endmodule
